// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Shifts take one cycle per bit and MUL is an iterative shift-add.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             res_zero,
  output logic             a_is_zero
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_PASSB = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     alu_out_q, alu_out_d;
  logic                 carry_q, carry_d;
  logic                 res_zero_q, res_zero_d;
  logic                 a_is_zero_q, a_is_zero_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 multi;
  logic [SW-1:0]        shamt;
  logic [WIDTH:0]       add_sum, sub_diff, mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     sc_res, ex_res;
  logic                 sc_carry, ex_carry;

  // Ready is held low for the whole time reset is asserted, not just after the next edge.
  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign shamt    = in_b[SW-1:0];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    alu_out_d   = alu_out_q;
    carry_d     = carry_q;
    res_zero_d  = res_zero_q;
    a_is_zero_d = a_is_zero_q;
    out_valid_d = out_valid_q;

    add_sum  = {1'b0, in_a} + {1'b0, in_b};
    sub_diff = {1'b0, in_a} - {1'b0, in_b};
    sc_res   = in_a;
    sc_carry = 1'b0;
    case (opcode)
      OP_ADD:   begin sc_res = add_sum[WIDTH-1:0];  sc_carry = add_sum[WIDTH];  end
      OP_SUB:   begin sc_res = sub_diff[WIDTH-1:0]; sc_carry = sub_diff[WIDTH]; end
      OP_AND:   sc_res = in_a & in_b;
      OP_XOR:   sc_res = in_a ^ in_b;
      OP_OR:    sc_res = in_a | in_b;
      OP_PASSB: sc_res = in_b;
      default:  sc_res = in_a;
    endcase
    multi = (opcode == OP_MUL) ||
            (((opcode == OP_SHL) || (opcode == OP_SHR)) && (shamt != '0));

    // Shift-add step: add the multiplicand into the high half, then shift the pair right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    ex_res   = '0;
    ex_carry = 1'b0;

    case (state_q)
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OP_MUL: begin
            acc_d    = mul_next;
            ex_res   = mul_next[WIDTH-1:0];
            ex_carry = |mul_next[2*WIDTH-1:WIDTH];
          end
          OP_SHL: begin
            ex_res   = acc_q[WIDTH-1:0] << 1;
            ex_carry = acc_q[WIDTH-1];
            acc_d    = {{WIDTH{1'b0}}, ex_res};
          end
          default: begin
            ex_res   = acc_q[WIDTH-1:0] >> 1;
            ex_carry = acc_q[0];
            acc_d    = {{WIDTH{1'b0}}, ex_res};
          end
        endcase
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          alu_out_d   = ex_res;
          carry_d     = ex_carry;
          res_zero_d  = (ex_res == '0);
          a_is_zero_d = (a_q == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Acceptance overrides the retire above, so DONE can chain straight into a new op.
    if (accept) begin
      op_d = opcode;
      a_d  = in_a;
      if (multi) begin
        state_d     = EXEC;
        out_valid_d = 1'b0;
        if (opcode == OP_MUL) begin
          acc_d = {{WIDTH{1'b0}}, in_b};
          cnt_d = CW'(WIDTH);
        end else begin
          acc_d = {{WIDTH{1'b0}}, in_a};
          cnt_d = CW'(shamt);
        end
      end else begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        alu_out_d   = sc_res;
        carry_d     = sc_carry;
        res_zero_d  = (sc_res == '0);
        a_is_zero_d = (in_a == '0);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      res_zero_q  <= 1'b0;
      a_is_zero_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      alu_out_q   <= alu_out_d;
      carry_q     <= carry_d;
      res_zero_q  <= res_zero_d;
      a_is_zero_q <= a_is_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign carry     = carry_q;
  assign res_zero  = res_zero_q;
  assign a_is_zero = a_is_zero_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits; legal values are powers of two, 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port opcode, input, 4 bits: operation select.
REQ-007 SHALL have ports in_a and in_b, inputs, WIDTH bits each: the operands.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port alu_out, output, WIDTH bits: the registered result.
REQ-011 SHALL have port carry, output, 1 bit: the carry, borrow, shift-out or overflow flag.
REQ-012 SHALL have port res_zero, output, 1 bit: alu_out equals 0.
REQ-013 SHALL have port a_is_zero, output, 1 bit: the captured in_a equals 0.

Function
REQ-014 Opcodes SHALL decode as follows:
- 2 ADD, 3 AND, 4 XOR, 5 PASSB, 8 SUB (a-b), 9 OR, 10 SHL, 11 SHR (logical), 12 MUL.
- 0, 1, 6, 7, 13, 14 and 15 are PASSA.
REQ-015 The state machine SHALL have three states: IDLE, EXEC and DONE.
- IDLE to EXEC on acceptance of a multi-cycle op.
- IDLE to DONE on acceptance of a single-cycle op.
- EXEC to DONE when the op completes.
- DONE to IDLE when out_ready is high and no new request is accepted.
REQ-016 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both high; in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-017 Acceptance in DONE SHALL retire the current result and start the new op in the same edge, giving back-to-back throughput.
REQ-018 The block SHALL capture opcode, in_a and in_b at acceptance; later input changes SHALL have no effect on the op in flight.
REQ-019 Latency L, from the accept edge to the first edge after which out_valid=1, SHALL be:
- 1 for single-cycle ops (ADD, AND, XOR, OR, SUB, PASSA, PASSB, and shifts by 0);
- 1+n for SHL/SHR, where n = in_b[log2(WIDTH)-1:0];
- WIDTH+1 for MUL.
REQ-020 SHL/SHR SHALL shift by one bit per EXEC cycle.
REQ-021 MUL SHALL use iterative shift-add over WIDTH EXEC cycles with a 2*WIDTH-bit unsigned accumulator; alu_out SHALL be the low WIDTH bits.
REQ-022 The carry flag SHALL be set as follows:
- ADD: carry-out of bit WIDTH-1.
- SUB: borrow, i.e. 1 when in_a < in_b unsigned.
- SHL/SHR: the last bit shifted out, or 0 when n=0.
- MUL: 1 when the high half of the product is nonzero.
- All other ops: 0.
REQ-023 All arithmetic SHALL be unsigned and modulo 2^WIDTH.
REQ-024 alu_out, carry, res_zero and a_is_zero SHALL update only at completion and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 out_valid SHALL drop on the edge where out_ready=1 unless a new single-cycle op is accepted on that same edge.
REQ-026 in_ready SHALL be 0 throughout EXEC; in_valid in that state SHALL be ignored.

Reset
REQ-027 While rst=1: state=IDLE, out_valid=0, alu_out=0, carry=0, res_zero=0, a_is_zero=0, in_ready=0, and all internal counters and accumulators are 0.
REQ-028 Reset asserted mid-operation SHALL abort the op with no out_valid pulse; in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-029 The bench SHALL cover these directed scenarios at WIDTH=8:
- ADD F0+20 -> alu_out=10, carry=1, out_valid after 1 edge; SUB 05-07 -> FE, carry=1.
- MUL 0D*0B -> 8F, carry=0, L=9; MUL 20*10 -> 00, carry=1, res_zero=1.
- SHR 81 by 1 -> 40, carry=1, L=2; SHL 81 by 3 -> 08, carry=0, L=4; SHL by 0 -> 81, carry=0, L=1.
- Hold out_ready=0 for 5 cycles after an ADD -> outputs stable, in_ready=0; then out_ready=1 with an XOR 0F^FF pending -> accepted the same edge, alu_out=F0 next.
- Assert rst at EXEC cycle 4 of a MUL -> no out_valid, all outputs 0; after release, ADD 01+01 -> 02.
- PASSA opcode 13 with in_a=00 -> alu_out=00, a_is_zero=1, res_zero=1; in_valid during EXEC -> ignored.
